// File: rtl/p2s_pkg.sv
// Shared types and elaboration-time helpers for the parallel2serial_mc converter.
package p2s_pkg;

  localparam int unsigned P2S_STATE_W = 2;

  typedef enum logic [P2S_STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_WORK  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bits needed to index n items; never less than one so counters stay declarable.
  function automatic int unsigned p2s_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

  // Main-clock cycles per s_clk half period.
  function automatic int unsigned p2s_half_cycles(input int unsigned p_freq,
                                                  input int unsigned s_freq);
    return 1 + (p_freq - 1) / s_freq / 2;
  endfunction

endpackage

// File: rtl/p2s_frame_fifo.sv
// Synchronous frame FIFO; read data is the head entry, valid in the same cycle as pop.
module p2s_frame_fifo
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [p2s_clog2(DEPTH):0]  o_level
);

  localparam int unsigned PTR_W = p2s_clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [LVL_W-1:0] w_count_nxt;

  assign w_push      = i_push & ~r_full;
  assign w_pop       = i_pop & ~r_empty;
  assign w_count_nxt = r_count + LVL_W'(w_push) - LVL_W'(w_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LVL_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_count;

endmodule

// File: rtl/parallel2serial_mc.sv
// Multi-channel parallel-to-serial converter: frame FIFO feeding lanes that share s_clk/s_clr.
// Define P2S_LATCH_EN to stretch DONE to one s_clk period with an s_latch strobe.
module parallel2serial_mc
  import p2s_pkg::*;
#(
  parameter int unsigned P_CLK_FREQ  = 100,
  parameter int unsigned S_CLK_FREQ  = 10,
  parameter int unsigned DATA_BITS   = 32,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CODE_ENDIAN = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS*DATA_BITS-1:0]     in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [p2s_clog2(FIFO_DEPTH):0]    level,
  output logic                              busy,
  output logic                              finish,
  output logic                              s_clk,
  output logic                              s_clr,
  output logic [CHANNELS-1:0]               s_dat,
  output logic                              s_latch
);

  localparam int unsigned HC      = p2s_half_cycles(P_CLK_FREQ, S_CLK_FREQ);
  localparam int unsigned DIV_W   = p2s_clog2(HC);
  localparam int unsigned BIT_W   = p2s_clog2(DATA_BITS);
  localparam int unsigned DCNT_W  = p2s_clog2(2 * HC);
  localparam int unsigned FRAME_W = CHANNELS * DATA_BITS;
  localparam int unsigned BUF_W   = DATA_BITS + 1;
`ifdef P2S_LATCH_EN
  localparam int unsigned DONE_LEN = 2 * HC;
  localparam bit          LATCH_ON = 1'b1;
`else
  localparam int unsigned DONE_LEN = 1;
  localparam bit          LATCH_ON = 1'b0;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [DIV_W-1:0]    w_div_run;
  logic                r_sclk;
  logic                w_sclk_nxt;
  logic                w_sclk_run;
  logic [BIT_W-1:0]    r_bit;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [DCNT_W-1:0]   w_dcnt_nxt;
  logic                r_clr;
  logic                r_busy;
  logic                r_finish;
  logic                r_latch;
  logic                w_clr_nxt;
  logic                w_busy_nxt;
  logic                w_finish_nxt;
  logic                w_latch_nxt;

  logic                w_div_wrap;
  logic                w_fall;
  logic                w_pop;
  logic                w_load_clear;
  logic                w_load_work;
  logic                w_shift;

  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [FRAME_W-1:0]  w_fifo_rdata;
  logic [DATA_BITS-1:0] w_lane_ord [CHANNELS];
  logic [BUF_W-1:0]    r_buf [CHANNELS];

  assign w_push   = in_valid & ~w_full;
  assign in_ready = ~w_full;

  p2s_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Free-running divider step used while the serial clock is active.
  assign w_div_wrap = (r_div == DIV_W'(HC - 1));
  assign w_fall     = w_div_wrap & r_sclk;
  assign w_div_run  = w_div_wrap ? '0 : r_div + DIV_W'(1);
  assign w_sclk_run = w_div_wrap ? ~r_sclk : r_sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_sclk   <= 1'b0;
      r_bit    <= '0;
      r_dcnt   <= '0;
      r_clr    <= 1'b0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_latch  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_sclk   <= w_sclk_nxt;
      r_bit    <= w_bit_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_clr    <= w_clr_nxt;
      r_busy   <= w_busy_nxt;
      r_finish <= w_finish_nxt;
      r_latch  <= w_latch_nxt;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = '0;
    w_sclk_nxt   = 1'b0;
    w_bit_nxt    = r_bit;
    w_dcnt_nxt   = '0;
    w_pop        = 1'b0;
    w_load_clear = 1'b0;
    w_load_work  = 1'b0;
    w_shift      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_load_clear = 1'b1;
          w_state_nxt  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_div_nxt  = w_div_run;
        w_sclk_nxt = w_sclk_run;
        if (w_fall) begin
          w_shift     = 1'b1;
          w_bit_nxt   = '0;
          w_state_nxt = S_WORK;
        end
      end
      S_WORK: begin
        w_div_nxt  = w_div_run;
        w_sclk_nxt = w_sclk_run;
        if (w_fall) begin
          w_shift = 1'b1;
          if (r_bit == BIT_W'(DATA_BITS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (r_dcnt == DCNT_W'(DONE_LEN - 1)) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_load_work = 1'b1;
            w_bit_nxt   = '0;
            w_state_nxt = S_WORK;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_clr_nxt    = (w_state_nxt == S_CLEAR);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_finish_nxt = (w_state_nxt == S_DONE) && (w_dcnt_nxt == DCNT_W'(DONE_LEN - 1));
    w_latch_nxt  = LATCH_ON && (w_state_nxt == S_DONE) && (w_dcnt_nxt < DCNT_W'(HC));
  end

  // Lane extraction with optional bit reversal so the buffer always shifts toward bit 0.
  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      for (int b = 0; b < int'(DATA_BITS); b++) begin
        if (CODE_ENDIAN != 0) begin
          w_lane_ord[c][b] = w_fifo_rdata[c*int'(DATA_BITS) + int'(DATA_BITS) - 1 - b];
        end else begin
          w_lane_ord[c][b] = w_fifo_rdata[c*int'(DATA_BITS) + b];
        end
      end
    end
  end

  // A load from IDLE parks a zero in bit 0 so s_dat stays low through CLEAR.
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (rst) begin
        r_buf[c] <= '0;
      end else if (w_load_clear) begin
        r_buf[c] <= {w_lane_ord[c], 1'b0};
      end else if (w_load_work) begin
        r_buf[c] <= {1'b0, w_lane_ord[c]};
      end else if (w_shift) begin
        r_buf[c] <= {1'b0, r_buf[c][BUF_W-1:1]};
      end
    end
  end

  always_comb begin
    s_dat = '0;
    for (int c = 0; c < int'(CHANNELS); c++) s_dat[c] = r_buf[c][0];
  end

  assign s_clk   = r_sclk;
  assign s_clr   = r_clr;
  assign busy    = r_busy;
  assign finish  = r_finish;
  assign s_latch = r_latch;

endmodule
